// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int PktCountW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester above LastGrant, one-hot.
module rr_picker #(
    parameter  int NumReq = 4,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] Valid,
    input  logic [IdxW-1:0]   LastGrant,
    output logic [NumReq-1:0] Pick
);

    logic [IdxW:0]       w_shamt;
    logic [NumReq-1:0]   w_rot;
    logic [NumReq-1:0]   w_rot_oh;

    // Rotate so the search start lands on bit 0, isolate the lowest set bit, rotate back.
    assign w_shamt  = {1'b0, LastGrant} + (IdxW+1)'(1);
    assign w_rot    = NumReq'({Valid, Valid} >> w_shamt);
    assign w_rot_oh = w_rot & (~w_rot + NumReq'(1));
    assign Pick     = NumReq'(({w_rot_oh, w_rot_oh} << w_shamt) >> NumReq);

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-locked round-robin arbiter steering NumReq requesters into one FIFO write port.
// Optional FIFO_ARB_WATERMARK_EN: hold off new grants while FifoProgFull is high.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int Width  = 8
) (
    input  logic                    Clk,
    input  logic                    ResetN,
    input  logic [NumReq-1:0]       ReqValid,
    input  logic [NumReq*Width-1:0] ReqData,
    input  logic [NumReq-1:0]       ReqLast,
    output logic [NumReq-1:0]       ReqReady,
    input  logic                    FifoFull,
    input  logic                    FifoProgFull,
    output logic                    FifoWrite,
    output logic [Width:0]          FifoDin,
    output logic [NumReq-1:0]       Grant,
    output logic [PktCountW-1:0]    PktCount
);

    localparam int IdxW = $clog2(NumReq);

    state_t               r_state, w_state_next;
    logic [NumReq-1:0]    r_grant, w_grant_next;
    logic [IdxW-1:0]      r_owner, w_owner_next;
    logic [IdxW-1:0]      r_last_grant, w_last_grant_next;
    logic [PktCountW-1:0] r_pkt_count, w_pkt_count_next;
    logic [NumReq-1:0]    w_pick;
    logic [IdxW-1:0]      w_pick_idx;
    logic [Width-1:0]     w_payload [NumReq];
    logic                 w_arb_ok;
    logic                 w_fire;

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_slice
            assign w_payload[gi] = ReqData[gi*Width +: Width];
        end
    endgenerate

`ifdef FIFO_ARB_WATERMARK_EN
    assign w_arb_ok = ~FifoProgFull;
`else
    logic w_unused_prog_full;
    assign w_unused_prog_full = FifoProgFull;
    assign w_arb_ok           = 1'b1;
`endif

    rr_picker #(.NumReq(NumReq)) u_picker (
        .Valid     (ReqValid),
        .LastGrant (r_last_grant),
        .Pick      (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_pick[i]) w_pick_idx = IdxW'(i);
        end
    end

    assign w_fire = (r_state == XFER) & ReqValid[r_owner] & ~FifoFull;

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        w_pkt_count_next  = r_pkt_count;
        ReqReady          = '0;
        FifoWrite         = 1'b0;
        FifoDin           = '0;
        case (r_state)
            IDLE: begin
                if ((|ReqValid) && w_arb_ok) begin
                    w_grant_next = w_pick;
                    w_owner_next = w_pick_idx;
                    w_state_next = XFER;
                end
            end
            XFER: begin
                ReqReady  = r_grant & {NumReq{~FifoFull}};
                FifoWrite = w_fire;
                FifoDin   = {ReqLast[r_owner], w_payload[r_owner]};
                // Ownership is released only on an accepted end-of-packet beat.
                if (w_fire && ReqLast[r_owner]) begin
                    w_last_grant_next = r_owner;
                    w_pkt_count_next  = r_pkt_count + PktCountW'(1);
                    w_grant_next      = '0;
                    w_state_next      = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_grant <= IdxW'(NumReq-1);
            r_pkt_count  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
            r_pkt_count  <= w_pkt_count_next;
        end
    end

    assign Grant    = r_grant;
    assign PktCount = r_pkt_count;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with an expected-write scoreboard.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic             Clk = 1'b0;
    logic             ResetN;
    logic [NR-1:0]    ReqValid;
    logic [NR*W-1:0]  ReqData;
    logic [NR-1:0]    ReqLast;
    logic [NR-1:0]    ReqReady;
    logic             FifoFull;
    logic             FifoProgFull;
    logic             FifoWrite;
    logic [W:0]       FifoDin;
    logic [NR-1:0]    Grant;
    logic [15:0]      PktCount;

    always #5 Clk = ~Clk;

    fifo_write_arbiter #(.NumReq(NR), .Width(W)) dut (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .ReqValid     (ReqValid),
        .ReqData      (ReqData),
        .ReqLast      (ReqLast),
        .ReqReady     (ReqReady),
        .FifoFull     (FifoFull),
        .FifoProgFull (FifoProgFull),
        .FifoWrite    (FifoWrite),
        .FifoDin      (FifoDin),
        .Grant        (Grant),
        .PktCount     (PktCount)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc_n    = 0;
    int            n_writes = 0;
    logic [W:0]    rq [NR][$];
    logic [W:0]    exp_q [$];
    logic [NR-1:0] gnt_log [$];
    int            wcyc_log [$];
    logic [NR-1:0] acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        logic [W:0] b;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                b = rq[i][0];
                ReqValid[i]       = 1'b1;
                ReqData[i*W +: W] = b[W-1:0];
                ReqLast[i]        = b[W];
            end else begin
                ReqValid[i]       = 1'b0;
                ReqData[i*W +: W] = '0;
                ReqLast[i]        = 1'b0;
            end
        end
    endtask

    // Queue a beat on requester i and record it as the next expected FIFO word.
    task automatic beat(input int i, input logic [W-1:0] d, input logic last);
        rq[i].push_back({last, d});
        exp_q.push_back({last, d});
    endtask

    task automatic cyc();
        logic [W:0] expw;
        @(negedge Clk);
        cyc_n++;
        if (FifoWrite === 1'b1) begin
            n_writes++;
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                expw = exp_q.pop_front();
                check("fifo_din", 32'(FifoDin), 32'(expw));
            end
            gnt_log.push_back(Grant);
            wcyc_log.push_back(cyc_n);
        end
        if (FifoFull === 1'b1) begin
            check("write_while_full", 32'(FifoWrite), 32'd0);
            check("ready_while_full", 32'(ReqReady), 32'd0);
        end
        acc = ReqValid & ReqReady;
        @(posedge Clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
        end
        refresh();
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < 200), 32'd1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        gnt_log.delete();
        wcyc_log.delete();
        refresh();
    endtask

    task automatic reset_dut();
        ResetN = 1'b0;
        clear_all();
        cyc();
        cyc();
        ResetN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n0;
        logic [NR-1:0] exp_g;

        ResetN       = 1'b0;
        ReqValid     = '1;
        ReqData      = 32'hA5A5_A5A5;
        ReqLast      = '1;
        FifoFull     = 1'b0;
        FifoProgFull = 1'b0;
        #2;
        check("rst_grant",     32'(Grant),     32'd0);
        check("rst_pktcount",  32'(PktCount),  32'd0);
        check("rst_ready",     32'(ReqReady),  32'd0);
        check("rst_fifowrite", 32'(FifoWrite), 32'd0);
        check("rst_fifodin",   32'(FifoDin),   32'd0);
        clear_all();
        cyc();
        cyc();
        ResetN = 1'b1;

        // Two 3-beat packets from requesters 0 and 2
        beat(0, 8'h11, 1'b0); beat(0, 8'h12, 1'b0); beat(0, 8'h13, 1'b1);
        beat(2, 8'h21, 1'b0); beat(2, 8'h22, 1'b0); beat(2, 8'h23, 1'b1);
        refresh();
        cyc();
        check("t1_first_grant", 32'(Grant), 32'h1);
        drain("t1");
        check("t1_pktcount", 32'(PktCount), 32'd2);
        check("t1_nwrites",  32'(gnt_log.size()), 32'd6);
        check("t1_grant_beat0", 32'(gnt_log[0]), 32'h1);
        check("t1_grant_beat2", 32'(gnt_log[2]), 32'h1);
        check("t1_grant_beat3", 32'(gnt_log[3]), 32'h4);
        check("t1_grant_beat5", 32'(gnt_log[5]), 32'h4);
        check("t1_back_to_back", 32'(wcyc_log[1] - wcyc_log[0]), 32'd1);
        check("t1_bubble",       32'(wcyc_log[3] - wcyc_log[2]), 32'd2);
        check("t1_grant_clear",  32'(Grant), 32'd0);

        // All requesters continuously holding single-beat packets
        reset_dut();
        beat(0, 8'hA0, 1'b1); beat(1, 8'hA1, 1'b1); beat(2, 8'hA2, 1'b1);
        beat(3, 8'hA3, 1'b1); beat(0, 8'hA4, 1'b1); beat(1, 8'hA5, 1'b1);
        refresh();
        drain("t2");
        check("t2_nwrites", 32'(gnt_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            exp_g = NR'(1) << (k % NR);
            check($sformatf("t2_grant_%0d", k), 32'(gnt_log[k]), 32'(exp_g));
        end
        for (int k = 1; k < 6; k++) begin
            check($sformatf("t2_spacing_%0d", k), 32'(wcyc_log[k] - wcyc_log[k-1]), 32'd2);
        end
        check("t2_pktcount", 32'(PktCount), 32'd6);

        // FifoFull stall during beat 2 of a 4-beat packet
        gnt_log.delete();
        wcyc_log.delete();
        n0 = n_writes;
        beat(3, 8'h31, 1'b0); beat(3, 8'h32, 1'b0); beat(3, 8'h33, 1'b0); beat(3, 8'h34, 1'b1);
        refresh();
        cyc();
        check("t3_grant", 32'(Grant), 32'h8);
        cyc();
        FifoFull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t3_grant_held", 32'(Grant), 32'h8);
        end
        FifoFull = 1'b0;
        drain("t3");
        check("t3_nwrites", 32'(n_writes - n0), 32'd4);
        check("t3_stall_len", 32'(wcyc_log[1] - wcyc_log[0]), 32'd6);
        check("t3_pktcount", 32'(PktCount), 32'd7);

        // Reset mid-packet
        beat(1, 8'h41, 1'b1);
        refresh();
        drain("t4a");
        n0 = n_writes;
        beat(2, 8'h51, 1'b0); beat(2, 8'h52, 1'b0); beat(2, 8'h53, 1'b0); beat(2, 8'h54, 1'b1);
        refresh();
        cyc();
        check("t4_grant", 32'(Grant), 32'h4);
        cyc();
        cyc();
        check("t4_two_beats", 32'(n_writes - n0), 32'd2);
        ResetN = 1'b0;
        #1;
        check("t4_rst_grant",    32'(Grant),     32'd0);
        check("t4_rst_pktcount", 32'(PktCount),  32'd0);
        check("t4_rst_write",    32'(FifoWrite), 32'd0);
        check("t4_rst_ready",    32'(ReqReady),  32'd0);
        clear_all();
        cyc();
        ResetN = 1'b1;
        beat(0, 8'h61, 1'b1); beat(3, 8'h63, 1'b1);
        refresh();
        cyc();
        check("t4_post_rst_grant", 32'(Grant), 32'h1);
        drain("t4b");
        check("t4_pktcount", 32'(PktCount), 32'd2);

        // Programmable-full in IDLE
        FifoProgFull = 1'b1;
        beat(1, 8'h71, 1'b1);
        refresh();
`ifdef FIFO_ARB_WATERMARK_EN
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t5_no_grant_progfull", 32'(Grant), 32'd0);
        end
        FifoProgFull = 1'b0;
        cyc();
        check("t5_grant_after_fall", 32'(Grant), 32'h2);
`else
        cyc();
        check("t5_grant_ignores_progfull", 32'(Grant), 32'h2);
`endif
        drain("t5");
        FifoProgFull = 1'b0;
        check("t5_pktcount", 32'(PktCount), 32'd3);

        // Packet counter wrap
        force dut.r_pkt_count = 16'hFFFE;
        #1;
        release dut.r_pkt_count;
        #1;
        check("t6_preload", 32'(PktCount), 32'h0000_FFFE);
        beat(0, 8'h81, 1'b1);
        refresh();
        drain("t6a");
        check("t6_ffff", 32'(PktCount), 32'h0000_FFFF);
        beat(2, 8'h82, 1'b1);
        refresh();
        drain("t6b");
        check("t6_wrap", 32'(PktCount), 32'h0000_0000);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
